// File: rtl/led7_scan_capture.sv
// led7_scan_capture
//   Watches a multiplexed, active-low 7-segment display bus and recovers the hex value
//   shown on each digit. The bus is double-flop synchronised, must hold unchanged for
//   STABLE_CYC consecutive comparisons, and is then decoded once into the selected
//   digit's register set.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         synchronous active-low reset
//   seg_i          segment lines {g,f,e,d,c,b,a}, 0 = lit
//   dig_sel_n_i    per-digit enables, active-low, expected one-hot-low
//   digits_o       recovered values, digit i at [4i+3:4i]
//   digit_on_o     1 = digit shows a glyph, 0 = blank
//   digit_err_o    1 = last committed pattern was not a legal glyph
//   upd_valid_o    1-cycle pulse, a digit register was written
//   upd_idx_o      index of the digit written with upd_valid_o
//   bus_err_o      1-cycle pulse, a stable sample had more than one enable low
module led7_scan_capture #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   digit_on_o,
    output logic [NUM_DIGITS-1:0]   digit_err_o,
    output logic                    upd_valid_o,
    output logic [2:0]              upd_idx_o,
    output logic                    bus_err_o
);

    localparam int unsigned BusW = 7 + NUM_DIGITS;
    localparam int unsigned CntW = $clog2(STABLE_CYC + 1);

    logic [BusW-1:0] s1_q, s2_q, s2_prev_q;
    // Shift register marking how far post-reset samples have travelled down the
    // s1 -> s2 -> s2_prev chain; counting waits until the comparison sees only them.
    logic [2:0]      prime_q, prime_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]      on_q, on_d;
    logic [NUM_DIGITS-1:0]      err_q, err_d;
    logic                       upd_valid_q, upd_valid_d;
    logic [2:0]                 upd_idx_q, upd_idx_d;
    logic                       bus_err_q, bus_err_d;

    logic [6:0]            seg_s2;
    logic [NUM_DIGITS-1:0] sel_s2;
    logic                  same;
    logic                  commit;
    logic                  glyph_ok;
    logic [3:0]            glyph_val;
    logic [3:0]            low_cnt;
    logic [2:0]            low_idx;

    assign seg_s2 = s2_q[BusW-1 -: 7];
    assign sel_s2 = s2_q[NUM_DIGITS-1:0];

    // Stability counter; commit fires on the single STABLE_CYC-1 -> STABLE_CYC step.
    always_comb begin
        same    = (s2_q == s2_prev_q);
        prime_d = {prime_q[1:0], 1'b1};
        cnt_d   = cnt_q;
        if (!prime_q[2] || !same) begin
            cnt_d = '0;
        end else if (cnt_q < CntW'(STABLE_CYC)) begin
            cnt_d = cnt_q + CntW'(1);
        end
        commit = prime_q[2] && same && (cnt_q == CntW'(STABLE_CYC - 1));
    end

    // Segment pattern back to hex value.
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_val = 4'h0;
        case (seg_s2)
            7'h40:   glyph_val = 4'h0;
            7'h79:   glyph_val = 4'h1;
            7'h24:   glyph_val = 4'h2;
            7'h30:   glyph_val = 4'h3;
            7'h19:   glyph_val = 4'h4;
            7'h12:   glyph_val = 4'h5;
            7'h02:   glyph_val = 4'h6;
            7'h78:   glyph_val = 4'h7;
            7'h00:   glyph_val = 4'h8;
            7'h10:   glyph_val = 4'h9;
            7'h08:   glyph_val = 4'hA;
            7'h03:   glyph_val = 4'hB;
            7'h46:   glyph_val = 4'hC;
            7'h21:   glyph_val = 4'hD;
            7'h06:   glyph_val = 4'hE;
            7'h0E:   glyph_val = 4'hF;
            default: glyph_ok  = 1'b0;
        endcase
    end

    // Count active enables; low_idx is only meaningful when exactly one is low.
    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_s2[i]) begin
                low_cnt = low_cnt + 4'd1;
                low_idx = 3'(i);
            end
        end
    end

    always_comb begin
        digits_d    = digits_q;
        on_d        = on_q;
        err_d       = err_q;
        upd_valid_d = 1'b0;
        upd_idx_d   = upd_idx_q;
        bus_err_d   = 1'b0;
        if (commit) begin
            if (low_cnt == 4'd1) begin
                upd_valid_d = 1'b1;
                upd_idx_d   = low_idx;
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (!sel_s2[i]) begin
                        if (seg_s2 == 7'h7F) begin
                            // Blank: value keeps its previous contents.
                            on_d[i]  = 1'b0;
                            err_d[i] = 1'b0;
                        end else begin
                            on_d[i]     = 1'b1;
                            err_d[i]    = !glyph_ok;
                            digits_d[i] = glyph_val;
                        end
                    end
                end
            end else if (low_cnt > 4'd1) begin
                bus_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q        <= '1;
            s2_q        <= '1;
            s2_prev_q   <= '1;
            prime_q     <= '0;
            cnt_q       <= '0;
            digits_q    <= '0;
            on_q        <= '0;
            err_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            s1_q        <= {seg_i, dig_sel_n_i};
            s2_q        <= s1_q;
            s2_prev_q   <= s2_q;
            prime_q     <= prime_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            on_q        <= on_d;
            err_q       <= err_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign digits_o    = digits_q;
    assign digit_on_o  = on_q;
    assign digit_err_o = err_q;
    assign upd_valid_o = upd_valid_q;
    assign upd_idx_o   = upd_idx_q;
    assign bus_err_o   = bus_err_q;

endmodule
